wb_regfile_sb: RTL and testbench

- Write-back end of the MEM/WB interface. Consumes the WB-stage control and data fields, selects the write-back value and commits it to an 8-entry register file.
- Serves two decode-stage read ports with same-cycle write-through bypass.
- Holds a per-register load scoreboard. The scoreboard raises a decode stall while a source register still has a load in flight.

---
 rtl/wb_regfile_sb.sv | 113 +++++++++++
 tb/tb_wb_regfile_sb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_sb.sv
// Write-back stage register file with write-through read bypass and a
// per-register load scoreboard that drives the decode-stage load-use stall.
module wb_regfile_sb #(
   parameter int DATA_WIDTH    = 16,
   parameter int REGADDR_WIDTH = 3,
   parameter int ZERO_REG      = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_reg_write,
   input  logic                     wb_mem_to_reg,
   input  logic [DATA_WIDTH-1:0]    wb_read_data,
   input  logic [DATA_WIDTH-1:0]    wb_alu_result,
   input  logic [REGADDR_WIDTH-1:0] wb_rd,
   input  logic [REGADDR_WIDTH-1:0] rs1_addr,
   input  logic [REGADDR_WIDTH-1:0] rs2_addr,
   output logic [DATA_WIDTH-1:0]    rs1_data,
   output logic [DATA_WIDTH-1:0]    rs2_data,
   output logic [DATA_WIDTH-1:0]    wb_write_data,
   input  logic                     id_rs1_used,
   input  logic                     id_rs2_used,
   input  logic                     id_issue,
   input  logic                     id_issue_load,
   input  logic [REGADDR_WIDTH-1:0] id_issue_rd,
   input  logic                     flush,
   output logic                     id_stall,
   output logic                     sb_overflow
);

   localparam int NREG = 2**REGADDR_WIDTH;
   typedef logic [REGADDR_WIDTH-1:0] addr_t;

   logic [DATA_WIDTH-1:0] regs_q [NREG];
   logic [DATA_WIDTH-1:0] regs_d [NREG];
   logic [1:0]            cnt_q  [NREG];
   logic [1:0]            cnt_d  [NREG];
   logic                  ovf_q;
   logic                  ovf_d;
   logic                  commit_en;
   logic                  inc_en;
   logic                  dec_en;
   logic                  pend1;
   logic                  pend2;

   function automatic logic hardwired_zero(input addr_t a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign wb_write_data = wb_mem_to_reg ? wb_read_data : wb_alu_result;
   assign commit_en     = wb_reg_write && !hardwired_zero(wb_rd);
   assign inc_en        = id_issue && id_issue_load && !hardwired_zero(id_issue_rd);
   assign dec_en        = commit_en && wb_mem_to_reg;

   // Read ports: an in-progress write-back is visible in the same cycle.
   assign rs1_data = hardwired_zero(rs1_addr) ? '0 :
                     (commit_en && (wb_rd == rs1_addr)) ? wb_write_data : regs_q[rs1_addr];
   assign rs2_data = hardwired_zero(rs2_addr) ? '0 :
                     (commit_en && (wb_rd == rs2_addr)) ? wb_write_data : regs_q[rs2_addr];

   // A source whose last outstanding load is landing now is bypassed, so it
   // no longer needs to stall.
   assign pend1 = !hardwired_zero(rs1_addr) && (cnt_q[rs1_addr] != 2'd0) &&
                  !((cnt_q[rs1_addr] == 2'd1) && dec_en && (wb_rd == rs1_addr));
   assign pend2 = !hardwired_zero(rs2_addr) && (cnt_q[rs2_addr] != 2'd0) &&
                  !((cnt_q[rs2_addr] == 2'd1) && dec_en && (wb_rd == rs2_addr));

   assign id_stall    = (id_rs1_used && pend1) || (id_rs2_used && pend2);
   assign sb_overflow = ovf_q;

   // Next state for the register file, scoreboard counters and overflow flag.
   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
         cnt_d[i]  = cnt_q[i];
         if (commit_en && (wb_rd == addr_t'(i))) begin
            regs_d[i] = wb_write_data;
         end
         if (flush) begin
            cnt_d[i] = 2'd0;
         end else if (inc_en && (id_issue_rd == addr_t'(i)) &&
                      !(dec_en && (wb_rd == addr_t'(i)))) begin
            if (cnt_q[i] == 2'd3) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 2'd1;
            end
         end else if (dec_en && (wb_rd == addr_t'(i)) &&
                      !(inc_en && (id_issue_rd == addr_t'(i))) &&
                      (cnt_q[i] != 2'd0)) begin
            cnt_d[i] = cnt_q[i] - 2'd1;
         end
      end
   end

   // State registers with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= 2'd0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Scoreboard bench for wb_regfile_sb: stimulus pushes expected outputs from a
// behavioural model into a queue, a negedge monitor pops and compares.
module tb_wb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wb_reg_write = 1'b0;
   logic        wb_mem_to_reg = 1'b0;
   logic [15:0] wb_read_data = '0;
   logic [15:0] wb_alu_result = '0;
   logic [2:0]  wb_rd = '0;
   logic [2:0]  rs1_addr = '0;
   logic [2:0]  rs2_addr = '0;
   logic [15:0] rs1_data;
   logic [15:0] rs2_data;
   logic [15:0] wb_write_data;
   logic        id_rs1_used = 1'b0;
   logic        id_rs2_used = 1'b0;
   logic        id_issue = 1'b0;
   logic        id_issue_load = 1'b0;
   logic [2:0]  id_issue_rd = '0;
   logic        flush = 1'b0;
   logic        id_stall;
   logic        sb_overflow;

   wb_regfile_sb #(.DATA_WIDTH(16), .REGADDR_WIDTH(3), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_write_data(wb_write_data),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_issue(id_issue), .id_issue_load(id_issue_load), .id_issue_rd(id_issue_rd),
      .flush(flush), .id_stall(id_stall), .sb_overflow(sb_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst; bit we; bit m2r; logic [15:0] rdat; logic [15:0] alu; logic [2:0] rd;
      logic [2:0] a1; logic [2:0] a2; bit u1; bit u2;
      bit iss; bit ild; logic [2:0] ird; bit fl; bit gate;
   } stim_t;

   typedef struct {
      int cyc; logic [15:0] rs1; logic [15:0] rs2; logic [15:0] wbd; bit stall; bit ovf;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   bit done = 0;

   // Reference model: architectural register values, outstanding-load counts.
   logic [15:0] m_regs[8];
   int          m_cnt[8];
   bit          m_ovf = 0;

   initial begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_cnt[i] = 0; end
   end

   function automatic stim_t idle();
      stim_t s;
      s.rst = 1; s.we = 0; s.m2r = 0; s.rdat = '0; s.alu = '0; s.rd = '0;
      s.a1 = '0; s.a2 = '0; s.u1 = 0; s.u2 = 0;
      s.iss = 0; s.ild = 0; s.ird = '0; s.fl = 0; s.gate = 0;
      return s;
   endfunction

   task automatic cyc(input stim_t s_in);
      stim_t s;
      exp_t e;
      logic [15:0] wd;
      bit wr, dec, inc, p1, p2;
      s = s_in;
      @(posedge clk);
      #1;
      wd  = s.m2r ? s.rdat : s.alu;
      wr  = s.we && (s.rd != 0);
      dec = wr && s.m2r;
      e.cyc = cyc_n;
      e.wbd = wd;
      e.rs1 = (s.a1 == 0) ? 16'h0 : (wr && s.rd == s.a1) ? wd : m_regs[s.a1];
      e.rs2 = (s.a2 == 0) ? 16'h0 : (wr && s.rd == s.a2) ? wd : m_regs[s.a2];
      p1 = (s.a1 != 0) && (m_cnt[s.a1] > 0) && !(m_cnt[s.a1] == 1 && dec && s.rd == s.a1);
      p2 = (s.a2 != 0) && (m_cnt[s.a2] > 0) && !(m_cnt[s.a2] == 1 && dec && s.rd == s.a2);
      e.stall = (s.u1 && p1) || (s.u2 && p2);
      e.ovf = m_ovf;
      if (s.gate && e.stall) s.iss = 0;
      inc = s.iss && s.ild && (s.ird != 0);

      reset = s.rst; wb_reg_write = s.we; wb_mem_to_reg = s.m2r;
      wb_read_data = s.rdat; wb_alu_result = s.alu; wb_rd = s.rd;
      rs1_addr = s.a1; rs2_addr = s.a2; id_rs1_used = s.u1; id_rs2_used = s.u2;
      id_issue = s.iss; id_issue_load = s.ild; id_issue_rd = s.ird; flush = s.fl;
      exp_q.push_back(e);
      cyc_n++;

      // State after the coming edge.
      if (!s.rst) begin
         for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_cnt[i] = 0; end
         m_ovf = 0;
      end else begin
         if (wr) m_regs[s.rd] = wd;
         if (s.fl) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
         end else if (!(inc && dec && s.ird == s.rd)) begin
            if (inc) begin
               if (m_cnt[s.ird] == 3) m_ovf = 1;
               else m_cnt[s.ird] = m_cnt[s.ird] + 1;
            end
            if (dec && m_cnt[s.rd] > 0) m_cnt[s.rd] = m_cnt[s.rd] - 1;
         end
      end
   endtask

   task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rs1_data", e.cyc, rs1_data, e.rs1);
            chk("rs2_data", e.cyc, rs2_data, e.rs2);
            chk("wb_write_data", e.cyc, wb_write_data, e.wbd);
            chk("id_stall", e.cyc, {15'h0, id_stall}, {15'h0, e.stall});
            chk("sb_overflow", e.cyc, {15'h0, sb_overflow}, {15'h0, e.ovf});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before end of stimulus");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      s = idle(); s.rst = 0; cyc(s); cyc(s);
      // r3 write with bypass, hold, then reset.
      s = idle(); s.we = 1; s.alu = 16'h1234; s.rd = 3; s.a1 = 3; cyc(s);
      s = idle(); s.a1 = 3; cyc(s); cyc(s); cyc(s);
      s = idle(); s.rst = 0; s.a1 = 3; cyc(s);
      s = idle(); s.a1 = 3; cyc(s);
      // Load data select into r5, dropped write to r0.
      s = idle(); s.we = 1; s.m2r = 1; s.rdat = 16'hBEEF; s.alu = 16'h0001; s.rd = 5; s.a1 = 5; cyc(s);
      s = idle(); s.a1 = 5; s.a2 = 5; cyc(s);
      s = idle(); s.we = 1; s.alu = 16'hFFFF; s.rd = 0; s.a1 = 0; cyc(s);
      s = idle(); s.a1 = 0; cyc(s);
      // Load-use on r2, resolved by same-cycle write-back.
      s = idle(); s.iss = 1; s.ild = 1; s.ird = 2; cyc(s);
      s = idle(); s.a2 = 2; s.u2 = 1; cyc(s);
      s = idle(); s.we = 1; s.m2r = 1; s.rdat = 16'h00AA; s.rd = 2; s.a2 = 2; s.u2 = 1; cyc(s);
      s = idle(); s.a2 = 2; s.u2 = 1; cyc(s);
      // Simultaneous issue and write-back on r4.
      s = idle(); s.iss = 1; s.ild = 1; s.ird = 4; cyc(s);
      s = idle(); s.iss = 1; s.ild = 1; s.ird = 4; s.we = 1; s.m2r = 1; s.rdat = 16'h0044;
      s.rd = 4; s.a1 = 4; s.u1 = 1; cyc(s);
      s = idle(); s.a1 = 4; s.u1 = 1; cyc(s);
      // Saturation of r6 and flush.
      for (int k = 0; k < 4; k++) begin
         s = idle(); s.iss = 1; s.ild = 1; s.ird = 6; s.a1 = 6; s.u1 = 1; cyc(s);
      end
      s = idle(); s.a1 = 6; s.u1 = 1; cyc(s);
      s = idle(); s.fl = 1; s.a1 = 6; s.u1 = 1; cyc(s);
      s = idle(); s.a1 = 6; s.u1 = 1; cyc(s);
      // Reset and flush together with pending loads and an active write.
      s = idle(); s.iss = 1; s.ild = 1; s.ird = 1; s.we = 1; s.alu = 16'h7777; s.rd = 7; cyc(s);
      s = idle(); s.iss = 1; s.ild = 1; s.ird = 7; cyc(s);
      s = idle(); s.rst = 0; s.fl = 1; s.we = 1; s.alu = 16'h5A5A; s.rd = 2;
      s.iss = 1; s.ild = 1; s.ird = 3; cyc(s);
      for (int k = 0; k < 8; k++) begin
         s = idle(); s.a1 = 3'(k); s.a2 = 3'(7 - k); s.u1 = 1; s.u2 = 1; cyc(s);
      end
      // Randomized traffic with issue gated by the stall.
      for (int k = 0; k < 3000; k++) begin
         s = idle();
         s.rst  = ($urandom_range(0, 199) != 0);
         s.we   = $urandom_range(0, 1);
         s.m2r  = ($urandom_range(0, 2) != 0);
         s.rdat = 16'($urandom);
         s.alu  = 16'($urandom);
         s.rd   = 3'($urandom_range(0, 7));
         s.a1   = 3'($urandom_range(0, 7));
         s.a2   = 3'($urandom_range(0, 7));
         s.u1   = $urandom_range(0, 1);
         s.u2   = $urandom_range(0, 1);
         s.iss  = $urandom_range(0, 1);
         s.ild  = ($urandom_range(0, 2) != 0);
         s.ird  = 3'($urandom_range(0, 7));
         s.fl   = ($urandom_range(0, 49) == 0);
         s.gate = 1;
         cyc(s);
      end
      s = idle(); cyc(s);
      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
